// File: rtl/dual_channel_mem_ctrl_if.sv
// Request/response bundle between the shared processor bus and the main-memory
// stage: an independent read channel and write channel, each with its own busy
// flag and one-cycle completion pulse.
// Ports: rd_req/rd_addr -> rd_data/rd_valid/read_busy ; wr_req/wr_addr/wr_data -> wr_done/write_busy.
interface dual_channel_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              read_busy;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              write_busy;

  // Bus side: issues requests, observes completions and stall flags.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_data, rd_valid, read_busy, wr_done, write_busy
  );

  // Memory side: the controller.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_data, rd_valid, read_busy, wr_done, write_busy
  );
endinterface

// File: rtl/dual_channel_mem_ctrl.sv
// Main-memory stage: 2^ADDR_W x DATA_W array with independent fixed-latency read
// and write channels; read response at accept+RD_LAT, write commit at accept+WR_LAT.
// Ports: clk, rst (async active-low), bus (slave modport). Requests seen while a
// channel is busy (including its completion edge) are dropped, never queued.
module dual_channel_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_channel_mem_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int RD_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WR_CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [RD_CW-1:0] RD_LOAD = RD_CW'(RD_LAT - 1);
  localparam logic [WR_CW-1:0] WR_LOAD = WR_CW'(WR_LAT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Power-up image: each location holds its own index. Reset never touches it.
  function automatic mem_t mem_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(i);
    return img;
  endfunction

  mem_t mem = mem_image();

  state_t              rd_state, rd_state_n;
  logic [RD_CW-1:0]    rd_cnt, rd_cnt_n;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_n;
  logic                rd_fire;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  state_t              wr_state, wr_state_n;
  logic [WR_CW-1:0]    wr_cnt, wr_cnt_n;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_n;
  logic [DATA_W-1:0]   wr_data_q, wr_data_n;
  logic                wr_fire;
  logic                wr_done_q;

  // Read channel next-state: the counter is loaded with RD_LAT-1 on accept so
  // that the response edge lands exactly RD_LAT edges after the accept edge.
  always_comb begin
    rd_state_n = rd_state;
    rd_cnt_n   = rd_cnt;
    rd_addr_n  = rd_addr_q;
    rd_fire    = 1'b0;
    case (rd_state)
      IDLE: begin
        if (bus.rd_req) begin
          rd_addr_n  = bus.rd_addr;
          rd_cnt_n   = RD_LOAD;
          rd_state_n = WAIT;
        end
      end
      WAIT: begin
        if (rd_cnt == '0) begin
          rd_fire    = 1'b1;
          rd_state_n = IDLE;
        end else begin
          rd_cnt_n = rd_cnt - 1'b1;
        end
      end
      default: rd_state_n = IDLE;
    endcase
  end

  // Write channel next-state, same shape as the read side.
  always_comb begin
    wr_state_n = wr_state;
    wr_cnt_n   = wr_cnt;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;
    wr_fire    = 1'b0;
    case (wr_state)
      IDLE: begin
        if (bus.wr_req) begin
          wr_addr_n  = bus.wr_addr;
          wr_data_n  = bus.wr_data;
          wr_cnt_n   = WR_LOAD;
          wr_state_n = WAIT;
        end
      end
      WAIT: begin
        if (wr_cnt == '0) begin
          wr_fire    = 1'b1;
          wr_state_n = IDLE;
        end else begin
          wr_cnt_n = wr_cnt - 1'b1;
        end
      end
      default: wr_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= IDLE;
      rd_cnt     <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_state   <= IDLE;
      wr_cnt     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      rd_state   <= rd_state_n;
      rd_cnt     <= rd_cnt_n;
      rd_addr_q  <= rd_addr_n;
      rd_valid_q <= rd_fire;
      wr_state   <= wr_state_n;
      wr_cnt     <= wr_cnt_n;
      wr_addr_q  <= wr_addr_n;
      wr_data_q  <= wr_data_n;
      wr_done_q  <= wr_fire;
      // A write committing on the response edge to the same address wins;
      // otherwise the array read sees its pre-edge contents.
      if (rd_fire) begin
        if (wr_fire && (wr_addr_q == rd_addr_q)) rd_data_q <= wr_data_q;
        else                                     rd_data_q <= mem[rd_addr_q];
      end
    end
  end

  // Array storage has no reset; a reset simply keeps wr_fire low.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr_q] <= wr_data_q;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.read_busy  = (rd_state == WAIT);
  assign bus.wr_done    = wr_done_q;
  assign bus.write_busy = (wr_state == WAIT);

endmodule

// File: tb/tb_dual_channel_mem_ctrl.sv
// Bench for dual_channel_mem_ctrl: directed scenarios followed by random traffic,
// checked against an edge-indexed reference model that pushes expected
// completions into queues popped by an independent monitor.
module tb_dual_channel_mem_ctrl;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dual_channel_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dual_channel_mem_ctrl #(
    .ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Edge counter: after the N-th rising edge, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int e; logic [7:0] d; } rsp_t;
  rsp_t rq[$];
  int   wq[$];
  rsp_t mon_r;
  int   mon_e;

  // Reference model state, expressed as edge numbers.
  logic [7:0] mm [256];
  bit         rd_pend, wr_pend;
  int         rd_resp, wr_commit, rd_free, wr_free, rd_acc, wr_acc;
  logic [7:0] rd_a, wr_a, wr_d;
  logic [7:0] last_rd;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rd_pend = 1'b0; wr_pend = 1'b0;
    rd_free = 0;    wr_free = 0;
    rd_acc  = -1000; wr_acc = -1000;
    last_rd = 8'h00;
  endtask

  // Evaluate what the coming edge e must do given the inputs presented to it.
  task automatic model(input int e, input logic rr, input logic [7:0] ra,
                       input logic wr, input logic [7:0] wa, input logic [7:0] wd);
    rsp_t r;
    if (rd_pend && e == rd_resp) begin
      r.e = e;
      r.d = (wr_pend && wr_commit == e && wr_a == rd_a) ? wr_d : mm[rd_a];
      rq.push_back(r);
      rd_pend = 1'b0;
    end
    if (wr_pend && e == wr_commit) begin
      mm[wr_a] = wr_d;
      wq.push_back(e);
      wr_pend = 1'b0;
    end
    if (rr && !rd_pend && e >= rd_free) begin
      rd_pend = 1'b1; rd_a = ra; rd_acc = e;
      rd_resp = e + RD_LAT; rd_free = e + RD_LAT + 1;
    end
    if (wr && !wr_pend && e >= wr_free) begin
      wr_pend = 1'b1; wr_a = wa; wr_d = wd; wr_acc = e;
      wr_commit = e + WR_LAT; wr_free = e + WR_LAT + 1;
    end
  endtask

  task automatic step(input logic rr, input logic [7:0] ra,
                      input logic wr, input logic [7:0] wa, input logic [7:0] wd);
    bus.rd_req  = rr; bus.rd_addr = ra;
    bus.wr_req  = wr; bus.wr_addr = wa; bus.wr_data = wd;
    model(cyc + 1, rr, ra, wr, wa, wd);
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " rd_data"},    bus.rd_data,    0);
    chk({tag, " rd_valid"},   bus.rd_valid,   0);
    chk({tag, " read_busy"},  bus.read_busy,  0);
    chk({tag, " wr_done"},    bus.wr_done,    0);
    chk({tag, " write_busy"}, bus.write_busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_outputs_zero("async reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("read_busy",  bus.read_busy,  (cyc >= rd_acc && cyc < rd_acc + RD_LAT));
      chk("write_busy", bus.write_busy, (cyc >= wr_acc && cyc < wr_acc + WR_LAT));
      while (rq.size() > 0 && rq[0].e < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL rd_valid missing: got none expected pulse at edge %0d", rq[0].e);
        void'(rq.pop_front());
      end
      while (wq.size() > 0 && wq[0] < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL wr_done missing: got none expected pulse at edge %0d", wq[0]);
        void'(wq.pop_front());
      end
      if (bus.rd_valid) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_valid unexpected: got pulse expected none (edge %0d)", cyc);
        end else begin
          mon_r = rq.pop_front();
          chk("rd_valid edge", cyc, mon_r.e);
          chk("rd_data", bus.rd_data, mon_r.d);
          last_rd = mon_r.d;
        end
      end else begin
        chk("rd_data hold", bus.rd_data, last_rd);
      end
      if (bus.wr_done) begin
        if (wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_done unexpected: got pulse expected none (edge %0d)", cyc);
        end else begin
          mon_e = wq.pop_front();
          chk("wr_done edge", cyc, mon_e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 8'(i);
    model_reset();
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    @(negedge clk);
    #2;
    chk_outputs_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    // Plain read of the power-up image.
    step(1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
    idle(5);
    // Write then read back.
    step(1'b0, 8'h00, 1'b1, 8'h05, 8'h01);
    idle(4);
    step(1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
    idle(5);
    // Same-edge accepts: commit precedes the response.
    step(1'b1, 8'h05, 1'b1, 8'h05, 8'h02);
    idle(5);
    // Write accepted one edge later completes on the response edge: forwarded.
    step(1'b1, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 1'b1, 8'h06, 8'hAA);
    idle(5);
    // Request held high; address changes while busy.
    step(1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 8'h06, 1'b0, 8'h00, 8'h00);
    idle(5);
    // Reset while a write is pending: it must never commit.
    step(1'b0, 8'h00, 1'b1, 8'h07, 8'h55);
    idle(1);
    do_reset();
    step(1'b1, 8'h07, 1'b0, 8'h00, 8'h00);
    idle(5);
    // Independent concurrent channels, then read back the written location.
    step(1'b1, 8'h10, 1'b1, 8'h20, 8'h33);
    idle(5);
    step(1'b1, 8'h20, 1'b0, 8'h00, 8'h00);
    idle(5);
    // Address extremes.
    step(1'b1, 8'hFF, 1'b1, 8'h00, 8'hC3);
    idle(5);
    step(1'b1, 8'h00, 1'b1, 8'hFF, 8'h3C);
    idle(5);
    step(1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    idle(5);

    // Random traffic over a small address window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      logic       rr, wr;
      logic [7:0] ra, wa, wd;
      rr = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wa = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(rr, ra, wr, wa, wd);
    end

    idle(8);
    chk("read queue drained",  rq.size(), 0);
    chk("write queue drained", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
